// File: rtl/bus_pkg.sv
// Types and sizing shared by the coherence bus controller and its L2 block adapter.
package bus_pkg;

  localparam int unsigned BLOCK_SIZE = 2;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = WORD_WIDTH * BLOCK_SIZE;
  localparam int unsigned OFF_W      = $clog2(4 * BLOCK_SIZE);

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  typedef logic [WORD_WIDTH-1:0] bus_word_t;

  // Word i of a block sits at bits [32*i +: 32].
  typedef bus_word_t [BLOCK_SIZE-1:0] transfer_width_t;

  function automatic logic block_aligned(input bus_word_t addr);
    return addr[OFF_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/l2_block_adapter_beat_watchdog.sv
// Counts consecutive stalled cycles on one beat; expire_c fires on the last allowed one.
module beat_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expire_c = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (!nRST || clr) begin
      count <= '0;
    end else if (en && !expire_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/l2_block_adapter.sv
// Splits L2 block reads/writes into sequential word beats on a busy-wait memory port.
module l2_block_adapter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  l2REN,
  input  logic                  l2WEN,
  input  logic [31:0]           l2addr,
  input  logic [DATA_WIDTH-1:0] l2store,
  output logic [DATA_WIDTH-1:0] l2load,
  output l2_state_t             l2state,
  output logic [31:0]           mem_addr,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byte_en,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_busy
);

  localparam int unsigned BEAT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE, S_ERR} fsm_t;

  fsm_t              state;
  logic [BEAT_W-1:0] beat;
  logic [31:0]       base;
  logic              is_write;
  transfer_width_t   store_q;
  transfer_width_t   load_q;

  logic              accept_c;
  logic              expire_c;
  logic              req_ok_c;
  logic [BEAT_W-1:0] beat_nxt_c;

  assign accept_c   = (mem_ren || mem_wen) && !mem_busy;
  assign req_ok_c   = (l2REN ^ l2WEN) && block_aligned(l2addr);
  assign beat_nxt_c = beat + BEAT_W'(1);
  assign l2load     = load_q;

  beat_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .nRST     (nRST),
    .clr      ((state != S_BEAT) || accept_c),
    .en       ((state == S_BEAT) && mem_busy),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state       <= S_IDLE;
      l2state     <= L2_FREE;
      beat        <= '0;
      base        <= '0;
      is_write    <= 1'b0;
      store_q     <= '0;
      load_q      <= '0;
      mem_addr    <= '0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_wdata   <= '0;
      mem_byte_en <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ok_c) begin
            state       <= S_BEAT;
            l2state     <= L2_BUSY;
            beat        <= '0;
            base        <= l2addr;
            is_write    <= l2WEN;
            mem_addr    <= l2addr;
            mem_ren     <= l2REN;
            mem_wen     <= l2WEN;
            mem_byte_en <= 4'hF;
            if (l2WEN) begin
              store_q   <= transfer_width_t'(l2store);
              mem_wdata <= l2store[WORD_WIDTH-1:0];
            end
          end else if (l2REN || l2WEN) begin
            // Conflicting or misaligned: report without touching memory.
            state   <= S_ERR;
            l2state <= L2_ERROR;
          end else begin
            l2state <= L2_FREE;
          end
        end

        S_BEAT: begin
          if (accept_c) begin
            if (!is_write) begin
              load_q[beat] <= mem_rdata;
            end
            if (beat == LAST_BEAT) begin
              state       <= S_DONE;
              l2state     <= L2_ACCESS;
              mem_ren     <= 1'b0;
              mem_wen     <= 1'b0;
              mem_byte_en <= '0;
            end else begin
              beat      <= beat_nxt_c;
              mem_addr  <= base + (32'(beat_nxt_c) << 2);
              mem_wdata <= store_q[beat_nxt_c];
            end
          end else if (expire_c) begin
            state       <= S_ERR;
            l2state     <= L2_ERROR;
            mem_ren     <= 1'b0;
            mem_wen     <= 1'b0;
            mem_byte_en <= '0;
          end
        end

        S_DONE, S_ERR: begin
          state   <= S_IDLE;
          l2state <= L2_FREE;
        end

        default: begin
          state   <= S_IDLE;
          l2state <= L2_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_block_adapter.sv
// Randomised bench: a transaction-level model predicts every cycle of each block transfer.
module tb_l2_block_adapter;
  import bus_pkg::*;

  localparam int unsigned TO = 8;

  logic                  clk = 1'b0;
  logic                  nRST;
  logic                  l2REN, l2WEN;
  logic [31:0]           l2addr;
  logic [DATA_WIDTH-1:0] l2store;
  logic [DATA_WIDTH-1:0] l2load;
  l2_state_t             l2state;
  logic [31:0]           mem_addr;
  logic                  mem_ren, mem_wen;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_byte_en;
  logic [31:0]           mem_rdata;
  logic                  mem_busy;

  l2_block_adapter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nRST(nRST), .l2REN(l2REN), .l2WEN(l2WEN), .l2addr(l2addr),
    .l2store(l2store), .l2load(l2load), .l2state(l2state), .mem_addr(mem_addr),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected outputs for the current cycle, written by the stimulus process.
  bit              chk_en = 0;
  bit              exp_reset = 0;
  l2_state_t       exp_state = L2_FREE;
  bit              exp_ren = 0, exp_wen = 0;
  logic [31:0]     exp_addr = '0, exp_wdata = '0;
  transfer_width_t exp_load = '0;
  transfer_width_t model_load = '0;

  task automatic chk(input string nm, input logic [DATA_WIDTH-1:0] act,
                     input logic [DATA_WIDTH-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("l2state", DATA_WIDTH'(l2state), DATA_WIDTH'(exp_state));
      chk("mem_ren", DATA_WIDTH'(mem_ren), DATA_WIDTH'(exp_ren));
      chk("mem_wen", DATA_WIDTH'(mem_wen), DATA_WIDTH'(exp_wen));
      chk("l2load", l2load, exp_load);
      if (exp_ren || exp_wen) begin
        chk("mem_addr", DATA_WIDTH'(mem_addr), DATA_WIDTH'(exp_addr));
        chk("mem_byte_en", DATA_WIDTH'(mem_byte_en), DATA_WIDTH'(4'hF));
      end
      if (exp_wen) chk("mem_wdata", DATA_WIDTH'(mem_wdata), DATA_WIDTH'(exp_wdata));
      if (exp_reset) begin
        chk("rst_addr", DATA_WIDTH'(mem_addr), '0);
        chk("rst_wdata", DATA_WIDTH'(mem_wdata), '0);
        chk("rst_byte_en", DATA_WIDTH'(mem_byte_en), '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One request; stalls[k] = busy cycles before beat k is accepted (>= TO means stuck).
  // rst_beat >= 0 pulses nRST in the first cycle of that beat. end_cyc = cycles from
  // request to ACCESS/ERROR, -2 when reset aborted the transfer.
  task automatic xfer(input bit ren, input bit wen, input logic [31:0] addr,
                      input transfer_width_t store, input transfer_width_t rdat,
                      input logic [BLOCK_SIZE-1:0][7:0] stalls, input int rst_beat,
                      output int end_cyc);
    int start;
    bit aborted;
    bit valid;
    start = cyc;
    end_cyc = -1;
    aborted = 0;
    valid = (ren ^ wen) && ((addr % (4 * BLOCK_SIZE)) == 0);
    l2REN = ren; l2WEN = wen; l2addr = addr; l2store = store;
    mem_busy = 1'($urandom_range(0, 1));
    exp_state = L2_FREE; exp_ren = 0; exp_wen = 0; exp_load = model_load;
    step();
    // Request inputs must be ignored from here on; scramble them.
    l2REN = 0; l2WEN = 0; l2addr = $urandom; l2store = {$urandom, $urandom};
    if (!valid) begin
      exp_state = L2_ERROR;
      end_cyc = cyc - start;
      step();
      exp_state = L2_FREE;
      step();
    end else begin
      for (int k = 0; k < BLOCK_SIZE && !aborted; k++) begin
        exp_state = L2_BUSY; exp_ren = ren; exp_wen = wen;
        exp_addr = addr + 32'(4 * k);
        exp_wdata = store[k];
        if (k == rst_beat) begin
          nRST = 0; mem_busy = 0; mem_rdata = $urandom;
          step();
          nRST = 1;
          model_load = '0;
          exp_reset = 1; exp_state = L2_FREE; exp_ren = 0; exp_wen = 0; exp_load = '0;
          step();
          exp_reset = 0;
          aborted = 1;
          end_cyc = -2;
        end else begin
          for (int s = 0; s < int'(stalls[k]) && s < int'(TO); s++) begin
            mem_busy = 1; mem_rdata = $urandom;
            step();
          end
          if (int'(stalls[k]) >= int'(TO)) begin
            exp_state = L2_ERROR; exp_ren = 0; exp_wen = 0;
            mem_busy = 1'($urandom_range(0, 1));
            end_cyc = cyc - start;
            step();
            exp_state = L2_FREE;
            step();
            aborted = 1;
          end else begin
            mem_busy = 0; mem_rdata = rdat[k];
            step();
            if (!wen) model_load[k] = rdat[k];
            exp_load = model_load;
          end
        end
      end
      if (!aborted) begin
        exp_state = L2_ACCESS; exp_ren = 0; exp_wen = 0;
        mem_busy = 1'($urandom_range(0, 1));
        end_cyc = cyc - start;
        step();
        exp_state = L2_FREE;
        step();
      end
    end
  endtask

  initial begin
    int ec;
    transfer_width_t st, rd;
    logic [BLOCK_SIZE-1:0][7:0] stl;
    logic [31:0] a;
    bit r, w;

    nRST = 0; l2REN = 0; l2WEN = 0; l2addr = '0; l2store = '0;
    mem_rdata = '0; mem_busy = 0;
    step();
    chk_en = 1; exp_reset = 1; exp_state = L2_FREE; exp_load = '0;
    step();
    nRST = 1;
    step();
    exp_reset = 0;

    // Zero-wait read.
    rd = {32'hBBBB_0002, 32'hAAAA_0001};
    xfer(1, 0, 32'h0000_1000, '0, rd, '0, -1, ec);
    chk("read_latency", DATA_WIDTH'(ec), DATA_WIDTH'(3));
    chk("read_block", l2load, 64'hBBBB0002_AAAA0001);

    // Write with a 3-cycle stall on beat 0.
    stl = {8'd0, 8'd3};
    xfer(0, 1, 32'h0000_2008, 64'h1111_2222_3333_4444, {$urandom, $urandom}, stl, -1, ec);
    chk("write_latency", DATA_WIDTH'(ec), DATA_WIDTH'(6));
    chk("write_keeps_load", l2load, 64'hBBBB0002_AAAA0001);

    // Misaligned read.
    xfer(1, 0, 32'h0000_1004, '0, '0, '0, -1, ec);
    chk("misalign_latency", DATA_WIDTH'(ec), DATA_WIDTH'(1));
    chk("misalign_keeps_load", l2load, 64'hBBBB0002_AAAA0001);

    // Conflicting request.
    xfer(1, 1, 32'h0000_3000, '0, '0, '0, -1, ec);
    chk("conflict_latency", DATA_WIDTH'(ec), DATA_WIDTH'(1));

    // Memory stuck busy on beat 1: accept beat 0 in cycle 1, TO busy cycles, then ERROR.
    stl = {8'(TO), 8'd0};
    xfer(1, 0, 32'h0000_4000, '0, {32'h5, 32'h6}, stl, -1, ec);
    chk("timeout_latency", DATA_WIDTH'(ec), DATA_WIDTH'(1 + TO + 1));

    // Reset during beat 1, then a clean read.
    xfer(1, 0, 32'h0000_5000, '0, {32'h7, 32'h8}, '0, 1, ec);
    chk("reset_abort", DATA_WIDTH'(ec), DATA_WIDTH'(-2));
    chk("reset_load", l2load, '0);
    xfer(1, 0, 32'h0000_6010, '0, {32'hCAFE_0002, 32'hF00D_0001}, '0, -1, ec);
    chk("post_reset_latency", DATA_WIDTH'(ec), DATA_WIDTH'(3));
    chk("post_reset_block", l2load, 64'hCAFE0002_F00D0001);

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      a = $urandom & ~32'h7;
      if (i % 13 == 0) a = 32'hFFFF_FFF8;
      r = 1'($urandom_range(0, 1));
      w = !r;
      if (op == 0) begin r = 1; w = 1; end
      if (op == 1) a = a | 32'($urandom_range(1, 7));
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        st[k] = $urandom;
        rd[k] = $urandom;
        stl[k] = 8'($urandom_range(0, 3));
      end
      if (op == 2) stl[$urandom_range(0, BLOCK_SIZE - 1)] = 8'(TO);
      xfer(r, w, a, st, rd, stl, (op == 3) ? int'($urandom_range(0, BLOCK_SIZE - 1)) : -1, ec);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        mem_busy = 1'($urandom_range(0, 1));
        step();
      end
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
